idct_1d_pipe: RTL and testbench

Pipelined 8-point one-dimensional inverse DCT for the JPEG decode path: it is the counterpart of the forward 1D DCT row/column engine. It accepts one vector of eight dequantized DCT coefficients per beat over a valid/ready handshake. It returns eight spatial-domain samples, rounded and saturated, after a fixed four-stage pipeline. Two instances, with a transpose buffer between them, form the 2D IDCT.

---
 rtl/idct_1d_pipe.sv | 117 +++++++++++
 tb/tb_idct_1d_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/idct_1d_pipe.sv
// idct_1d_pipe: 8-point 1D inverse DCT with an even/odd butterfly and five register levels.
// The pipeline stalls globally: every stage advances only when the output slot is free or being taken.
module idct_1d_pipe #(
    parameter int IW = 12,
    parameter int OW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic signed [IW-1:0] X0,
    input  logic signed [IW-1:0] X1,
    input  logic signed [IW-1:0] X2,
    input  logic signed [IW-1:0] X3,
    input  logic signed [IW-1:0] X4,
    input  logic signed [IW-1:0] X5,
    input  logic signed [IW-1:0] X6,
    input  logic signed [IW-1:0] X7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic signed [OW-1:0] x0,
    output logic signed [OW-1:0] x1,
    output logic signed [OW-1:0] x2,
    output logic signed [OW-1:0] x3,
    output logic signed [OW-1:0] x4,
    output logic signed [OW-1:0] x5,
    output logic signed [OW-1:0] x6,
    output logic signed [OW-1:0] x7
);
    localparam int AW = IW + 11;
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (OW - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    // Rows n=0..3 of the even (X0,X2,X4,X6) and odd (X1,X3,X5,X7) halves; row 7-n reuses row n.
    localparam int EC [4][4] = '{'{91, 118, 91, 49}, '{91, 49, -91, -118},
                                 '{91, -49, -91, 118}, '{91, -118, 91, -49}};
    localparam int OC [4][4] = '{'{126, 106, 71, 25}, '{106, -25, -126, -71},
                                 '{71, -126, 25, 106}, '{25, -71, 106, -126}};

    logic                 en;
    logic [4:0]           v, l;
    logic signed [IW-1:0] xe [4];
    logic signed [IW-1:0] xd [4];
    logic signed [AW-1:0] pe [4][4];
    logic signed [AW-1:0] po [4][4];
    logic signed [AW-1:0] e [4];
    logic signed [AW-1:0] o [4];
    logic signed [AW-1:0] b [8];
    logic signed [OW-1:0] y [8];

    function automatic logic signed [OW-1:0] sat(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] r;
        r = s >>> 8;
        return r > MAXV ? OW'(MAXV) : r < MINV ? OW'(MINV) : r[OW-1:0];
    endfunction

    assign en        = !v[4] || out_ready;
    assign in_ready  = en;
    assign out_valid = v[4];
    assign out_last  = l[4];
    assign x0 = y[0];
    assign x1 = y[1];
    assign x2 = y[2];
    assign x3 = y[3];
    assign x4 = y[4];
    assign x5 = y[5];
    assign x6 = y[6];
    assign x7 = y[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            l <= '0;
            for (int i = 0; i < 4; i++) begin
                xe[i] <= '0;
                xd[i] <= '0;
                e[i]  <= '0;
                o[i]  <= '0;
                for (int j = 0; j < 4; j++) begin
                    pe[i][j] <= '0;
                    po[i][j] <= '0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                b[i] <= '0;
                y[i] <= '0;
            end
        end else if (en) begin
            v <= {v[3:0], in_valid};
            l <= {l[3:0], in_valid && in_last};
            if (in_valid) begin
                xe <= '{X0, X2, X4, X6};
                xd <= '{X1, X3, X5, X7};
            end
            for (int n = 0; n < 4; n++) begin
                for (int j = 0; j < 4; j++) begin
                    if (v[0]) begin
                        pe[n][j] <= AW'(xe[j]) * AW'(EC[n][j]);
                        po[n][j] <= AW'(xd[j]) * AW'(OC[n][j]);
                    end
                end
                if (v[1]) begin
                    e[n] <= pe[n][0] + pe[n][1] + pe[n][2] + pe[n][3];
                    o[n] <= po[n][0] + po[n][1] + po[n][2] + po[n][3];
                end
                // The +128 rounding bias is folded into the butterfly so the last stage only shifts and clamps.
                if (v[2]) begin
                    b[n]     <= e[n] + o[n] + AW'(128);
                    b[7 - n] <= e[n] - o[n] + AW'(128);
                end
            end
            for (int n = 0; n < 8; n++)
                if (v[3]) y[n] <= sat(b[n]);
        end
    end
endmodule

// File: tb/tb_idct_1d_pipe.sv
// tb_idct_1d_pipe: directed and random checks of idct_1d_pipe against a matrix-form IDCT model.
// The coefficient table is built from the cosine formula; expected vectors queue in acceptance order.
module tb_idct_1d_pipe;
    localparam int IW = 12;
    localparam int OW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 in_ready, out_valid, out_last;
    logic signed [IW-1:0] xi [8];
    logic signed [OW-1:0] xo [8];

    int            tbl [8][8];
    logic [8*OW:0] exp_q [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            popped = 0;
    bit            acc_in;
    int            ev [8];

    always #5 clk = ~clk;

    idct_1d_pipe #(.IW(IW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .X0(xi[0]), .X1(xi[1]), .X2(xi[2]), .X3(xi[3]),
        .X4(xi[4]), .X5(xi[5]), .X6(xi[6]), .X7(xi[7]),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .x0(xo[0]), .x1(xo[1]), .x2(xo[2]), .x3(xo[3]),
        .x4(xo[4]), .x5(xo[5]), .x6(xo[6]), .x7(xo[7])
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8*OW:0] model(input logic signed [IW-1:0] v [8], input logic last);
        logic [8*OW:0] r;
        int s;
        r = '0;
        r[8*OW] = last;
        for (int n = 0; n < 8; n++) begin
            s = 128;
            for (int k = 0; k < 8; k++) s += tbl[n][k] * int'(v[k]);
            s = s >>> 8;
            s = s > 511 ? 511 : (s < -512 ? -512 : s);
            r[n*OW +: OW] = s[OW-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        logic [8*OW:0] e;
        @(negedge clk);
        acc_in = rst_n && in_valid && in_ready;
        if (rst_n && out_valid && out_ready) begin
            chk("unexpected_out", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int n = 0; n < 8; n++) chk($sformatf("x%0d", n), xo[n], $signed(e[n*OW +: OW]));
                chk("out_last", out_last, e[8*OW]);
                popped++;
            end
        end
        if (acc_in) begin
            exp_q.push_back(model(xi, in_last));
            vectors++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input int v0, input int v1);
        int c;
        for (int k = 0; k < 8; k++) xi[k] = '0;
        xi[0] = IW'(v0);
        xi[1] = IW'(v1);
        in_valid = 1'b1;
        in_last = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 10) begin
            tick();
            c++;
        end
        chk({tag, "_latency"}, c, 4);
        for (int n = 0; n < 8; n++) chk($sformatf("%s_x%0d", tag, n), xo[n], ev[n]);
        tick();
    endtask

    function automatic logic signed [IW-1:0] rnd();
        return IW'(int'($urandom_range(0, 4095)) - 2048);
    endfunction

    initial begin
        real r, ck;
        int p0, sent, stall_left, guard, c, seen;
        logic [8*OW:0] e;
        logic signed [IW-1:0] bp [6][8];
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 8; k++) begin
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                r = 128.0 * ck * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
                tbl[n][k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            end
        for (int k = 0; k < 8; k++) xi[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        for (int n = 0; n < 8; n++) chk($sformatf("rst_x%0d", n), xo[n], 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        ev = '{23, 23, 23, 23, 23, 23, 23, 23};
        directed("dc_pos", 64, 0);
        ev = '{-23, -23, -23, -23, -23, -23, -23, -23};
        directed("dc_neg", -64, 0);
        ev = '{126, 106, 71, 25, -25, -71, -106, -126};
        directed("ac1", 0, 256);
        ev = '{511, 511, 511, 511, 511, 511, 511, 511};
        directed("sat_pos", 2047, 0);
        ev = '{-512, -512, -512, -512, -512, -512, -512, -512};
        directed("sat_neg", -2048, 0);

        p0 = popped;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) xi[k] = rnd();
            in_valid = 1'b1;
            in_last = (i % 8 == 7);
            tick();
            chk("stream_accept", acc_in, 1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (5) tick();
        chk("stream_count", popped - p0, 16);
        chk("stream_drained", exp_q.size(), 0);

        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 8; k++) bp[i][k] = rnd();
        p0 = popped;
        sent = 0;
        stall_left = -1;
        guard = 0;
        while (popped - p0 < 6 && guard < 60) begin
            if (sent < 6) begin
                xi = bp[sent];
                in_valid = 1'b1;
                in_last = (sent == 5);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            if (stall_left < 0 && out_valid) stall_left = 5;
            out_ready = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                e = (exp_q.size() > 0) ? exp_q[0] : '0;
                for (int n = 0; n < 8; n++) chk($sformatf("bp_hold_x%0d", n), xo[n], $signed(e[n*OW +: OW]));
                chk("bp_hold_last", out_last, e[8*OW]);
                stall_left--;
            end
            tick();
            if (acc_in) sent++;
            guard++;
        end
        chk("bp_sent", sent, 6);
        chk("bp_count", popped - p0, 6);
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("bp_no_dup", exp_q.size(), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) xi[k] = rnd();
            in_valid = 1'b1;
            in_last = (i == 2);
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        c = 0;
        while (!out_valid && c < 10) begin
            tick();
            c++;
        end
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_last", out_last, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_x0", xo[0], 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            seen += int'(out_valid);
        end
        chk("post_rst_no_stale", seen, 0);
        ev = '{23, 23, 23, 23, 23, 23, 23, 23};
        directed("post_rst_dc", 64, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
